// File: rtl/spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_xfer_sequencer
//  Description : Sequences a 1-8 byte SPI transfer through the register port
//                of an SPI core: slave-select setup, per-byte TRDY/RRDY
//                polling with timeout, data write/read, slave-select release.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_sequencer #(
    parameter int          POLL_LIMIT = 255,
    parameter logic [15:0] SS_MASK    = 16'h0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_len,
    input  logic [63:0] tx_data,
    output logic [63:0] rx_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        spi_select,
    output logic        read_n,
    output logic        write_n,
    output logic [2:0]  mem_addr,
    output logic [15:0] data_from_cpu,
    input  logic [15:0] data_to_cpu
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SETSS   = 4'd1,
        SSO_ON  = 4'd2,
        POLL_T  = 4'd3,
        WR_TX   = 4'd4,
        POLL_R  = 4'd5,
        RD_RX   = 4'd6,
        SSO_OFF = 4'd7,
        FIN     = 4'd8
    } state_t;

    // Bus access phase: 0 = idle gap cycle, 1 = first active, 2 = second active
    localparam logic [1:0] PH_GAP  = 2'd0;
    localparam logic [1:0] PH_ACT1 = 2'd1;

    state_t        state_q;
    logic [1:0]    phase_q;
    logic [3:0]    len_q;
    logic [2:0]    idx_q;
    logic [63:0]   tx_q;
    logic [15:0]   poll_cnt_q;
    logic          err_flag_q;

    logic          cmd_ready_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          spi_select_q;
    logic          read_n_q;
    logic          write_n_q;
    logic [2:0]    mem_addr_q;
    logic [15:0]   data_q;
    logic [63:0]   rx_q;

    logic [2:0]    acc_addr_d;
    logic [15:0]   acc_data_d;
    logic          acc_rd_d;
    logic [15:0]   poll_cnt_d;
    logic          poll_expired_d;
    logic          last_byte_d;
    logic          len_ok_d;
    logic          unused_bits_d;

    // Register address/data/direction of the access belonging to each state
    always_comb begin
        acc_addr_d = 3'd0;
        acc_data_d = 16'h0000;
        acc_rd_d   = 1'b0;
        case (state_q)
            SETSS:   begin acc_addr_d = 3'd5; acc_data_d = SS_MASK;  end
            SSO_ON:  begin acc_addr_d = 3'd3; acc_data_d = 16'h0400; end
            POLL_T:  begin acc_addr_d = 3'd2; acc_rd_d   = 1'b1;     end
            WR_TX:   begin acc_addr_d = 3'd1; acc_data_d = {8'h00, tx_q[{idx_q, 3'b000} +: 8]}; end
            POLL_R:  begin acc_addr_d = 3'd2; acc_rd_d   = 1'b1;     end
            RD_RX:   begin acc_addr_d = 3'd0; acc_rd_d   = 1'b1;     end
            SSO_OFF: begin acc_addr_d = 3'd3; acc_data_d = 16'h0000; end
            default: begin acc_addr_d = 3'd0; end
        endcase
    end

    // Poll timeout, last-byte and length-legality decisions
    always_comb begin
        poll_cnt_d     = poll_cnt_q + 16'd1;
        poll_expired_d = (poll_cnt_d >= 16'(POLL_LIMIT));
        last_byte_d    = (({1'b0, idx_q} + 4'd1) == len_q);
        len_ok_d       = (cmd_len != 4'd0) && (cmd_len <= 4'd8);
        unused_bits_d  = ^data_to_cpu[15:8];
    end

    // Sequencer FSM with registered bus and handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= PH_GAP;
            len_q        <= 4'd0;
            idx_q        <= 3'd0;
            tx_q         <= 64'd0;
            poll_cnt_q   <= 16'd0;
            err_flag_q   <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            spi_select_q <= 1'b0;
            read_n_q     <= 1'b1;
            write_n_q    <= 1'b1;
            mem_addr_q   <= 3'd0;
            data_q       <= 16'h0000;
            rx_q         <= 64'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        len_q       <= cmd_len;
                        tx_q        <= tx_data;
                        idx_q       <= 3'd0;
                        phase_q     <= PH_GAP;
                        err_flag_q  <= 1'b0;
                        err_q       <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (len_ok_d) begin
                            state_q <= SETSS;
                        end else begin
                            // Illegal length: no bus traffic, report at once
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                SETSS, SSO_ON, POLL_T, WR_TX, POLL_R, RD_RX, SSO_OFF: begin
                    case (phase_q)
                        PH_GAP: begin
                            spi_select_q <= 1'b1;
                            mem_addr_q   <= acc_addr_d;
                            data_q       <= acc_data_d;
                            read_n_q     <= ~acc_rd_d;
                            write_n_q    <= acc_rd_d;
                            phase_q      <= 2'd1;
                        end
                        PH_ACT1: begin
                            phase_q <= 2'd2;
                        end
                        default: begin
                            // End of second active cycle: release and decide
                            spi_select_q <= 1'b0;
                            read_n_q     <= 1'b1;
                            write_n_q    <= 1'b1;
                            phase_q      <= PH_GAP;
                            case (state_q)
                                SETSS: state_q <= SSO_ON;
                                SSO_ON: begin
                                    state_q    <= POLL_T;
                                    poll_cnt_q <= 16'd0;
                                end
                                POLL_T: begin
                                    if (data_to_cpu[6]) begin
                                        state_q <= WR_TX;
                                    end else if (poll_expired_d) begin
                                        state_q    <= SSO_OFF;
                                        err_flag_q <= 1'b1;
                                    end else begin
                                        poll_cnt_q <= poll_cnt_d;
                                    end
                                end
                                WR_TX: begin
                                    state_q    <= POLL_R;
                                    poll_cnt_q <= 16'd0;
                                end
                                POLL_R: begin
                                    if (data_to_cpu[7]) begin
                                        state_q <= RD_RX;
                                    end else if (poll_expired_d) begin
                                        state_q    <= SSO_OFF;
                                        err_flag_q <= 1'b1;
                                    end else begin
                                        poll_cnt_q <= poll_cnt_d;
                                    end
                                end
                                RD_RX: begin
                                    rx_q[{idx_q, 3'b000} +: 8] <= data_to_cpu[7:0];
                                    if (last_byte_d) begin
                                        state_q <= SSO_OFF;
                                    end else begin
                                        idx_q      <= idx_q + 3'd1;
                                        state_q    <= POLL_T;
                                        poll_cnt_q <= 16'd0;
                                    end
                                end
                                default: begin
                                    state_q <= FIN;
                                    done_q  <= 1'b1;
                                    err_q   <= err_flag_q;
                                end
                            endcase
                        end
                    endcase
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign spi_select    = spi_select_q;
    assign read_n        = read_n_q;
    assign write_n       = write_n_q;
    assign mem_addr      = mem_addr_q;
    assign data_from_cpu = data_q;
    assign rx_data       = rx_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_xfer_sequencer
//  Description : Directed self-checking bench for spi_xfer_sequencer with a
//                loopback SPI core register model and bus protocol monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [3:0]  cmd_len;
    logic [63:0] tx_data;
    logic        cmd_ready, busy, done, err;
    logic [63:0] rx_data;
    logic        spi_select, read_n, write_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;

    // SPI core model state and bus logs
    logic        stuck;
    int          miss_cfg;
    logic        log_clr;
    logic        rrdy_m;
    logic [7:0]  rxbuf_m;
    int          fail_cnt;
    int          n_wr, n_rd, n_wr1, n_rd0, n_st, prot_err, run;
    logic [2:0]  a_hold;
    logic [15:0] d_hold;
    logic [18:0] wr_log [0:31];
    logic        trdy_w;
    logic        prot_bad_w;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_xfer_sequencer #(.POLL_LIMIT(4), .SS_MASK(16'h0001)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .tx_data(tx_data), .rx_data(rx_data), .busy(busy),
        .done(done), .err(err), .spi_select(spi_select), .read_n(read_n),
        .write_n(write_n), .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu)
    );

    assign trdy_w = !stuck && (fail_cnt >= miss_cfg);
    assign data_to_cpu = (mem_addr == 3'd2) ? {8'h00, rrdy_m, trdy_w, 6'h00} :
                         (mem_addr == 3'd0) ? {8'h00, rxbuf_m} : 16'h0000;
    assign prot_bad_w = spi_select ?
        ((read_n == write_n) || (run >= 2) ||
         ((run == 1) && ((mem_addr != a_hold) || (data_from_cpu != d_hold)))) :
        ((run == 1) || !read_n || !write_n);

    // Register model: logs each completed access and emulates loopback
    always @(posedge clk) begin
        if (reset) begin
            run    <= 0;
            rrdy_m <= 1'b0;
        end else begin
            if (prot_bad_w) prot_err <= prot_err + 1;
            if (spi_select) begin
                run <= run + 1;
                if (run == 0) begin
                    a_hold <= mem_addr;
                    d_hold <= data_from_cpu;
                end
                if (run == 1) begin
                    if (!write_n) begin
                        wr_log[n_wr[4:0]] <= {mem_addr, data_from_cpu};
                        n_wr <= n_wr + 1;
                        if (mem_addr == 3'd1) begin
                            n_wr1   <= n_wr1 + 1;
                            rxbuf_m <= data_from_cpu[7:0];
                            rrdy_m  <= 1'b1;
                        end
                    end else begin
                        n_rd <= n_rd + 1;
                        if (mem_addr == 3'd2) begin
                            n_st <= n_st + 1;
                            if (!trdy_w) fail_cnt <= fail_cnt + 1;
                        end
                        if (mem_addr == 3'd0) begin
                            n_rd0  <= n_rd0 + 1;
                            rrdy_m <= 1'b0;
                        end
                    end
                end
            end else begin
                run <= 0;
            end
        end
        if (log_clr) begin
            n_wr <= 0; n_rd <= 0; n_wr1 <= 0; n_rd0 <= 0; n_st <= 0;
            prot_err <= 0; fail_cnt <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
    endtask

    task automatic send(input logic [3:0] len, input logic [63:0] tx);
        cmd_len   = len;
        tx_data   = tx;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
    endtask

    // Watchdog so the run can never hang
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          extra;
        logic [63:0] mosi;
        reset = 1'b1; cmd_valid = 1'b0; cmd_len = 4'd0; tx_data = 64'd0;
        stuck = 1'b0; miss_cfg = 0; log_clr = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_ready",  {63'd0, cmd_ready}, 64'd1);
        chk("rst_busy",   {63'd0, busy}, 64'd0);
        chk("rst_done",   {63'd0, done}, 64'd0);
        chk("rst_err",    {63'd0, err}, 64'd0);
        chk("rst_bus",    {59'd0, spi_select, read_n, write_n, mem_addr == 3'd0, data_from_cpu == 16'h0}, 64'h0F);
        chk("rst_rx",     rx_data, 64'd0);
        reset = 1'b0;
        tick();
        clr_log();

        // 1-byte loopback
        send(4'd1, 64'hA5);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        wait_done("t1", cyc);
        chk("t1_lat",  64'(cyc), 64'd21);
        chk("t1_err",  {63'd0, err}, 64'd0);
        chk("t1_rx",   rx_data, 64'hA5);
        chk("t1_nwr",  64'(n_wr), 64'd4);
        chk("t1_w0",   64'(wr_log[0]), {45'd0, 3'd5, 16'h0001});
        chk("t1_w1",   64'(wr_log[1]), {45'd0, 3'd3, 16'h0400});
        chk("t1_w2",   64'(wr_log[2]), {45'd0, 3'd1, 16'h00A5});
        chk("t1_w3",   64'(wr_log[3]), {45'd0, 3'd3, 16'h0000});
        chk("t1_nst",  64'(n_st), 64'd2);
        chk("t1_prot", 64'(prot_err), 64'd0);
        tick();
        chk("t1_pulse", {62'd0, done, cmd_ready}, 64'd1);
        clr_log();

        // 8-byte loopback
        send(4'd8, 64'h0807060504030201);
        wait_done("t2", cyc);
        chk("t2_err", {63'd0, err}, 64'd0);
        chk("t2_rx",  rx_data, 64'h0807060504030201);
        chk("t2_cnt", {32'(n_wr1), 32'(n_rd0)}, {32'd8, 32'd8});
        mosi = 64'd0;
        for (int k = 0; k < 8; k++) mosi[8*k +: 8] = wr_log[2+k][7:0];
        chk("t2_mosi", mosi, 64'h0807060504030201);
        chk("t2_prot", 64'(prot_err), 64'd0);
        tick();

        // 2 bytes, TRDY misses 3 reads (one below the limit); upper rx kept
        miss_cfg = 3;
        clr_log();
        send(4'd2, 64'hBBCC);
        wait_done("t3", cyc);
        chk("t3_err", {63'd0, err}, 64'd0);
        chk("t3_rx",  rx_data, 64'h080706050403BBCC);
        chk("t3_nst", 64'(n_st), 64'd7);
        tick();
        miss_cfg = 0;

        // TRDY stuck low: timeout after 4 status reads
        stuck = 1'b1;
        clr_log();
        send(4'd1, 64'h11);
        wait_done("t4", cyc);
        chk("t4_lat", 64'(cyc), 64'd21);
        chk("t4_err", {63'd0, err}, 64'd1);
        chk("t4_nst", 64'(n_st), 64'd4);
        chk("t4_nwr", {32'(n_wr), 32'(n_wr1)}, {32'd3, 32'd0});
        chk("t4_off", 64'(wr_log[2]), {45'd0, 3'd3, 16'h0000});
        chk("t4_rx",  rx_data, 64'h080706050403BBCC);
        tick();
        stuck = 1'b0;

        // Illegal lengths 0 and 9
        clr_log();
        send(4'd0, 64'h55);
        chk("t5a_now", {60'd0, done, err, busy, cmd_ready}, 64'hE);
        tick();
        chk("t5a_after", {62'd0, done, cmd_ready}, 64'd1);
        send(4'd9, 64'h55);
        chk("t5b_now", {60'd0, done, err, busy, cmd_ready}, 64'hE);
        tick();
        chk("t5_nobus", 64'(n_wr + n_rd), 64'd0);
        chk("t5_rx", rx_data, 64'h080706050403BBCC);

        // Reset during second cycle of the WR_TX access
        clr_log();
        send(4'd1, 64'h5A);
        cyc = 0;
        while (!(spi_select === 1'b1 && write_n === 1'b0 && mem_addr === 3'd1) && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("t6_found", {63'd0, spi_select}, 64'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("t6_bus", {60'd0, spi_select, write_n, busy, cmd_ready}, 64'h5);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_nowr1", {32'(n_wr), 32'(n_wr1)}, {32'd2, 32'd0});
        clr_log();
        send(4'd1, 64'h77);
        wait_done("t6", cyc);
        chk("t6_err", {63'd0, err}, 64'd0);
        chk("t6_rx", rx_data, 64'h77);
        chk("t6_nwr", 64'(n_wr), 64'd4);
        tick();

        // cmd_valid held through a transfer and its done pulse
        clr_log();
        cmd_len = 4'd1; tx_data = 64'h3C; cmd_valid = 1'b1;
        tick();
        extra = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            if (cmd_ready === 1'b1) extra++;
            tick();
            cyc++;
        end
        chk("t7_done", {63'd0, done}, 64'd1);
        chk("t7_noready", {32'(extra), 31'd0, cmd_ready}, 64'd0);
        tx_data = 64'hC3;
        tick();
        chk("t7_idle", {62'd0, busy, cmd_ready}, 64'd1);
        tick();
        chk("t7_accept2", {63'd0, busy}, 64'd1);
        cmd_valid = 1'b0;
        wait_done("t7b", cyc);
        chk("t7_rx", rx_data, 64'hC3);
        tick(); tick();
        chk("t7_nothird", {62'd0, busy, cmd_ready}, 64'd1);
        chk("t7_prot", 64'(prot_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
